// File: rtl/lcd_sched_pkg.sv
// rtl/lcd_sched_pkg.sv - shared constants, command codes and FSM state types for the LCD frame scheduler
//
// Contents:
//   CHARS, IDX_W, BLANK       display geometry and clear-fill code
//   CMD_REFRESH, CMD_CURSOR   driver command encodings
//   clr_state_t, cur_state_t  clear-sweep and cursor FSM states
//   cursor_cmd()              builds the 3-bit cursor command from the on/off flag
package lcd_sched_pkg;

   localparam int         CHARS       = 32;
   localparam int         IDX_W       = 5;
   localparam logic [7:0] BLANK       = 8'h20;
   localparam logic [2:0] CMD_REFRESH = 3'b000;
   localparam logic [1:0] CMD_CURSOR  = 2'b01;

   typedef enum logic {
      CLR_IDLE = 1'b0,
      CLR_RUN  = 1'b1
   } clr_state_t;

   typedef enum logic [1:0] {
      CUR_IDLE  = 2'd0,
      CUR_WAIT  = 2'd1,
      CUR_ISSUE = 2'd2,
      CUR_HOLD  = 2'd3
   } cur_state_t;

   function automatic logic [2:0] cursor_cmd(input logic on);
      return {CMD_CURSOR, on};
   endfunction

endpackage

// File: rtl/lcd_rr_arb2.sv
// rtl/lcd_rr_arb2.sv - two-way round-robin arbiter for the character buffer write port
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset (last winner reset to requester 0)
//   req    in   [1:0] request vector, bit0 = requester A, bit1 = requester B
//   grant  out  [1:0] one-hot combinational grant for this cycle
module lcd_rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   // rr_last = 1 means B won the most recent contested or uncontested grant
   logic rr_last;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = rr_last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_last <= 1'b0;
      end else if (|grant) begin
         rr_last <= grant[1];
      end
   end

endmodule

// File: rtl/lcd_frame_scheduler.sv
// rtl/lcd_frame_scheduler.sv - character buffer, clear sweep, refresh index and cursor command sequencer for a 16x2 LCD driver
//
// Ports:
//   clk, reset                       clock and synchronous active-high reset
//   wr_valid_x/wr_addr_x/wr_data_x   requester A/B cell writes (address 0..31)
//   wr_ready_x                       combinational: this requester's write is taken this cycle
//   clr_req / clr_busy               start a BLANK fill of all cells / sweep in progress
//   cur_req, cur_on / cur_busy       request a cursor command / command pending or in flight
//   drv_ready, drv_drawing           driver refresh-loop and per-character strobes
//   character                        registered buffer[idx] presented to the driver
//   command_out                      registered driver command (refresh or cursor)
//   frame_done                       one-cycle pulse when idx wraps 31 -> 0
module lcd_frame_scheduler
   import lcd_sched_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_valid_a,
   input  logic [4:0] wr_addr_a,
   input  logic [7:0] wr_data_a,
   output logic       wr_ready_a,
   input  logic       wr_valid_b,
   input  logic [4:0] wr_addr_b,
   input  logic [7:0] wr_data_b,
   output logic       wr_ready_b,
   input  logic       clr_req,
   output logic       clr_busy,
   input  logic       cur_req,
   input  logic       cur_on,
   output logic       cur_busy,
   input  logic       drv_ready,
   input  logic       drv_drawing,
   output logic [7:0] character,
   output logic [2:0] command_out,
   output logic       frame_done
);

   logic [7:0]       cells [CHARS];
   clr_state_t       clr_state;
   logic [IDX_W-1:0] clr_idx;
   cur_state_t       cur_state;
   logic             cur_latched;
   logic [IDX_W-1:0] idx;
   logic             drawing_q;
   logic             ready_q;
   logic             draw_fall;
   logic             ready_rise;
   logic             ready_fall;
   logic [1:0]       wr_req;
   logic [1:0]       wr_grant;

   assign draw_fall  = drawing_q & ~drv_drawing;
   assign ready_rise = ~ready_q & drv_ready;
   assign ready_fall = ready_q & ~drv_ready;

   // The sweep owns the single buffer write port, so requesters are masked for
   // its whole duration; masking during reset keeps wr_ready low there too.
   assign wr_req = (reset || clr_state == CLR_RUN) ? 2'b00 : {wr_valid_b, wr_valid_a};

   lcd_rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (wr_req),
      .grant (wr_grant)
   );

   assign wr_ready_a = wr_grant[0];
   assign wr_ready_b = wr_grant[1];

   // Character buffer: at most one write per cycle, sweep has priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CHARS; i++) begin
            cells[i] <= BLANK;
         end
      end else if (clr_state == CLR_RUN) begin
         cells[clr_idx] <= BLANK;
      end else if (wr_grant[0]) begin
         cells[wr_addr_a] <= wr_data_a;
      end else if (wr_grant[1]) begin
         cells[wr_addr_b] <= wr_data_b;
      end
   end

   // Clear sweep: one cell per cycle, 0..CHARS-1, requests while running are dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         clr_state <= CLR_IDLE;
         clr_idx   <= '0;
         clr_busy  <= 1'b0;
      end else begin
         case (clr_state)
            CLR_IDLE: begin
               if (clr_req) begin
                  clr_state <= CLR_RUN;
                  clr_idx   <= '0;
                  clr_busy  <= 1'b1;
               end
            end
            CLR_RUN: begin
               clr_idx <= clr_idx + 1'b1;
               if (clr_idx == IDX_W'(CHARS - 1)) begin
                  clr_state <= CLR_IDLE;
                  clr_busy  <= 1'b0;
               end
            end
         endcase
      end
   end

   // Refresh index follows the driver: advance after each character, and snap
   // back to cell 0 whenever the driver re-enters its refresh loop.
   always_ff @(posedge clk) begin
      if (reset) begin
         drawing_q  <= 1'b0;
         ready_q    <= 1'b0;
         idx        <= '0;
         frame_done <= 1'b0;
      end else begin
         drawing_q  <= drv_drawing;
         ready_q    <= drv_ready;
         frame_done <= 1'b0;
         if (ready_rise) begin
            idx <= '0;
         end else if (draw_fall) begin
            idx        <= idx + 1'b1;
            frame_done <= (idx == IDX_W'(CHARS - 1));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         character <= BLANK;
      end else begin
         character <= cells[idx];
      end
   end

   // Cursor command: wait for the driver to be idle, hold the command until the
   // driver drops ready to take it, then wait for it to resume refreshing.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state   <= CUR_IDLE;
         cur_latched <= 1'b0;
         cur_busy    <= 1'b0;
         command_out <= CMD_REFRESH;
      end else begin
         case (cur_state)
            CUR_IDLE: begin
               if (cur_req) begin
                  cur_latched <= cur_on;
                  cur_state   <= CUR_WAIT;
                  cur_busy    <= 1'b1;
               end
            end
            CUR_WAIT: begin
               if (drv_ready) begin
                  cur_state   <= CUR_ISSUE;
                  command_out <= cursor_cmd(cur_latched);
               end
            end
            CUR_ISSUE: begin
               if (ready_fall) begin
                  cur_state   <= CUR_HOLD;
                  command_out <= CMD_REFRESH;
               end
            end
            CUR_HOLD: begin
               if (ready_rise) begin
                  cur_state <= CUR_IDLE;
                  cur_busy  <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// tb/tb_lcd_frame_scheduler.sv - self-checking bench for lcd_frame_scheduler
module tb_lcd_frame_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_valid_a = 1'b0;
   logic [4:0] wr_addr_a = '0;
   logic [7:0] wr_data_a = '0;
   logic       wr_ready_a;
   logic       wr_valid_b = 1'b0;
   logic [4:0] wr_addr_b = '0;
   logic [7:0] wr_data_b = '0;
   logic       wr_ready_b;
   logic       clr_req = 1'b0;
   logic       clr_busy;
   logic       cur_req = 1'b0;
   logic       cur_on = 1'b0;
   logic       cur_busy;
   logic       drv_ready = 1'b0;
   logic       drv_drawing = 1'b0;
   logic [7:0] character;
   logic [2:0] command_out;
   logic       frame_done;

   lcd_frame_scheduler dut (
      .clk         (clk),
      .reset       (reset),
      .wr_valid_a  (wr_valid_a),
      .wr_addr_a   (wr_addr_a),
      .wr_data_a   (wr_data_a),
      .wr_ready_a  (wr_ready_a),
      .wr_valid_b  (wr_valid_b),
      .wr_addr_b   (wr_addr_b),
      .wr_data_b   (wr_data_b),
      .wr_ready_b  (wr_ready_b),
      .clr_req     (clr_req),
      .clr_busy    (clr_busy),
      .cur_req     (cur_req),
      .cur_on      (cur_on),
      .cur_busy    (cur_busy),
      .drv_ready   (drv_ready),
      .drv_drawing (drv_drawing),
      .character   (character),
      .command_out (command_out),
      .frame_done  (frame_done)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cycle    = 0;
   int fd_count = 0;

   typedef struct {
      int         cyc;
      int         sel;
      logic [7:0] exp;
   } sb_item_t;
   sb_item_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;
   always @(negedge clk) if (frame_done === 1'b1) fd_count <= fd_count + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic fall();
      drv_drawing = 1'b1;
      cyc();
      drv_drawing = 1'b0;
      cyc();
   endtask

   // Scoreboard monitor: compares every expectation due in the current cycle.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cycle) begin
            case (sb[i].sel)
               0:       chk("sb character",  32'(character),  32'(sb[i].exp));
               1:       chk("sb frame_done", 32'(frame_done), 32'(sb[i].exp));
               2:       chk("sb wr_ready_a", 32'(wr_ready_a), 32'(sb[i].exp));
               default: chk("sb wr_ready_b", 32'(wr_ready_b), 32'(sb[i].exp));
            endcase
            sb.delete(i);
         end
      end
   end

   // Reference model state for the randomized phase
   logic [7:0] mem [32];
   int         idx_m;
   int         c;
   logic       last_b, pa, pb, dq, rq, dprev, rprev, fd_exp, ga, gb;
   logic [4:0] aa, ba;
   logic [7:0] ad, bd;

   initial begin
      int fd0;
      int busy;
      int bad;
      logic got;

      // reset state, with a request held to prove it is not granted
      wr_valid_a = 1'b1;
      cyc();
      cyc();
      @(negedge clk);
      chk("reset wr_ready_a", 32'(wr_ready_a), 32'h0);
      chk("reset wr_ready_b", 32'(wr_ready_b), 32'h0);
      chk("reset character", 32'(character), 32'h20);
      chk("reset command_out", 32'(command_out), 32'h0);
      chk("reset frame_done", 32'(frame_done), 32'h0);
      chk("reset clr_busy", 32'(clr_busy), 32'h0);
      chk("reset cur_busy", 32'(cur_busy), 32'h0);
      wr_valid_a = 1'b0;
      cyc();
      reset = 1'b0;

      // a full frame of blank cells, frame_done on the 32nd fall only
      drv_ready = 1'b1;
      cyc();
      cyc();
      fd0 = fd_count;
      for (int f = 1; f <= 32; f++) begin
         drv_drawing = 1'b1;
         cyc();
         if (f == 32) chk("no frame_done before fall 32", 32'(fd_count - fd0), 32'h0);
         @(negedge clk);
         chk("blank frame character", 32'(character), 32'h20);
         drv_drawing = 1'b0;
         cyc();
      end
      cyc();
      cyc();
      chk("one frame_done after fall 32", 32'(fd_count - fd0), 32'h1);

      // round robin: B wins alone, then A and B collide on cell 5
      wr_valid_b = 1'b1; wr_addr_b = 5'd0; wr_data_b = 8'h11;
      @(negedge clk);
      chk("lone B granted", 32'(wr_ready_b), 32'h1);
      cyc();
      wr_valid_a = 1'b1; wr_addr_a = 5'd5; wr_data_a = 8'h41;
      wr_addr_b = 5'd5; wr_data_b = 8'h42;
      @(negedge clk);
      chk("collide A granted", 32'(wr_ready_a), 32'h1);
      chk("collide B held", 32'(wr_ready_b), 32'h0);
      cyc();
      wr_valid_a = 1'b0;
      @(negedge clk);
      chk("collide B next", 32'(wr_ready_b), 32'h1);
      cyc();
      wr_valid_b = 1'b0;
      for (int f = 0; f < 5; f++) fall();
      cyc();
      cyc();
      @(negedge clk);
      chk("cell 5 after collide", 32'(character), 32'h42);

      // clear sweep with requester A waiting
      clr_req = 1'b1;
      cyc();
      clr_req = 1'b0;
      wr_valid_a = 1'b1; wr_addr_a = 5'd3; wr_data_a = 8'h55;
      busy = 0; bad = 0; got = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (clr_busy) begin
            busy++;
            if (wr_ready_a) bad++;
         end else begin
            got = wr_ready_a;
            break;
         end
         cyc();
      end
      chk("clr_busy cycles", 32'(busy), 32'd32);
      chk("wr_ready_a during clear", 32'(bad), 32'h0);
      chk("A granted after clear", 32'(got), 32'h1);
      cyc();
      wr_valid_a = 1'b0;
      cyc();
      @(negedge clk);
      chk("cell 5 cleared", 32'(character), 32'h20);
      drv_ready = 1'b0;
      cyc();
      drv_ready = 1'b1;
      cyc();
      cyc();
      for (int f = 0; f < 3; f++) fall();
      cyc();
      cyc();
      @(negedge clk);
      chk("cell 3 written after clear", 32'(character), 32'h55);

      // cursor command handshake
      drv_ready = 1'b0;
      cyc();
      cyc();
      cur_on = 1'b1; cur_req = 1'b1;
      cyc();
      cur_req = 1'b0; cur_on = 1'b0;
      @(negedge clk);
      chk("cur_busy set", 32'(cur_busy), 32'h1);
      chk("cursor waits", 32'(command_out), 32'h0);
      cyc();
      cyc();
      @(negedge clk);
      chk("cursor still waits", 32'(command_out), 32'h0);
      drv_ready = 1'b1;
      cyc();
      cyc();
      @(negedge clk);
      chk("cursor issued", 32'(command_out), 32'h3);
      cur_req = 1'b1;
      cyc();
      cur_req = 1'b0;
      cyc();
      @(negedge clk);
      chk("cur_req ignored while busy", 32'(command_out), 32'h3);
      drv_ready = 1'b0;
      cyc();
      cyc();
      @(negedge clk);
      chk("cursor hold command", 32'(command_out), 32'h0);
      chk("cursor hold busy", 32'(cur_busy), 32'h1);
      drv_ready = 1'b1;
      cyc();
      cyc();
      @(negedge clk);
      chk("cursor done", 32'(cur_busy), 32'h0);

      // drv_ready rise at idx 17 resyncs to cell 0 without frame_done
      wr_valid_a = 1'b1; wr_addr_a = 5'd0; wr_data_a = 8'hA0;
      cyc();
      wr_addr_a = 5'd17; wr_data_a = 8'hB1;
      cyc();
      wr_valid_a = 1'b0;
      for (int f = 0; f < 17; f++) fall();
      cyc();
      cyc();
      @(negedge clk);
      chk("cell 17 shown", 32'(character), 32'hB1);
      fd0 = fd_count;
      drv_ready = 1'b0;
      cyc();
      drv_ready = 1'b1;
      cyc();
      cyc();
      cyc();
      @(negedge clk);
      chk("resync to cell 0", 32'(character), 32'hA0);
      chk("no frame_done on resync", 32'(fd_count - fd0), 32'h0);

      // reset in the middle of a clear sweep
      clr_req = 1'b1;
      cyc();
      clr_req = 1'b0;
      repeat (10) cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      @(negedge clk);
      chk("clr_busy after reset", 32'(clr_busy), 32'h0);
      bad = 0;
      for (int f = 0; f < 32; f++) begin
         fall();
         cyc();
         @(negedge clk);
         if (character !== 8'h20) bad++;
      end
      chk("all cells blank after reset", 32'(bad), 32'h0);

      // reset while a cursor command is being issued
      drv_ready = 1'b0;
      cyc();
      cur_on = 1'b1; cur_req = 1'b1;
      cyc();
      cur_req = 1'b0;
      drv_ready = 1'b1;
      cyc();
      cyc();
      @(negedge clk);
      chk("cursor issued before reset", 32'(command_out), 32'h3);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      @(negedge clk);
      chk("command cleared by reset", 32'(command_out), 32'h0);
      chk("cur_busy cleared by reset", 32'(cur_busy), 32'h0);
      cyc();
      cyc();
      @(negedge clk);
      chk("no residual command", 32'(command_out), 32'h0);

      // randomized traffic against the reference model
      reset = 1'b1;
      drv_drawing = 1'b0; drv_ready = 1'b0; cur_on = 1'b0;
      wr_valid_a = 1'b0; wr_valid_b = 1'b0;
      cyc();
      reset = 1'b0;
      for (int i = 0; i < 32; i++) mem[i] = 8'h20;
      idx_m = 0; last_b = 1'b0; pa = 1'b0; pb = 1'b0;
      dq = 1'b0; rq = 1'b0; dprev = 1'b0; rprev = 1'b0;
      aa = '0; ba = '0; ad = '0; bd = '0;
      for (int n = 0; n < 400; n++) begin
         c = cycle;
         fd_exp = 1'b0;
         if (n > 0) begin
            if (!rq && rprev) begin
               idx_m = 0;
            end else if (dq && !dprev) begin
               fd_exp = (idx_m == 31);
               idx_m  = (idx_m + 1) % 32;
            end
            dq = dprev;
            rq = rprev;
         end
         sb.push_back('{c, 1, {7'd0, fd_exp}});
         sb.push_back('{c + 1, 0, mem[idx_m]});

         drv_drawing = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) drv_ready = ~drv_ready;
         if (!pa && $urandom_range(0, 2) == 0) begin
            pa = 1'b1;
            aa = 5'($urandom_range(0, 31));
            ad = 8'($urandom_range(0, 255));
         end
         if (!pb && $urandom_range(0, 2) == 0) begin
            pb = 1'b1;
            ba = 5'($urandom_range(0, 31));
            bd = 8'($urandom_range(0, 255));
         end
         wr_valid_a = pa; wr_addr_a = aa; wr_data_a = ad;
         wr_valid_b = pb; wr_addr_b = ba; wr_data_b = bd;

         ga = pa && (!pb || last_b);
         gb = pb && !ga;
         sb.push_back('{c, 2, {7'd0, ga}});
         sb.push_back('{c, 3, {7'd0, gb}});
         if (ga) begin
            mem[aa] = ad; last_b = 1'b0; pa = 1'b0;
         end else if (gb) begin
            mem[ba] = bd; last_b = 1'b1; pb = 1'b0;
         end
         dprev = drv_drawing;
         rprev = drv_ready;
         cyc();
      end
      wr_valid_a = 1'b0;
      wr_valid_b = 1'b0;
      cyc();
      cyc();
      cyc();
      chk("scoreboard drained", 32'(sb.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: timeout at cycle %0d, expected completion", cycle);
      $fatal(1);
   end

endmodule
